fetch_ctl: RTL and testbench
============================

# fetch_ctl

Program-counter and flag-holding stage directly upstream of the 8-bit ALU in the single-cycle core. Each cycle it produces the instruction address and holds the shift/carry bit that feeds the ALU's `sc_i`. It consumes the ALU's `zero` and `sc_o` outputs to resolve `bne` branches and carry/shift chaining. It also owns start/halt sequencing and a small writable branch-target lookup table.

## Interface
- `PC_W`, 10: program counter width; instruction memory depth is 2^PC_W.
- `LUT_AW`, 4: branch-target LUT address width; depth is 2^LUT_AW entries of `PC_W` bits.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse that begins program execution from pc 0.
- `halt_req` in 1: decoded halt instruction.
- `br_en` in 1: decoded `bne`; taken when `alu_zero`=0.
- `jmp_en` in 1: decoded unconditional jump.
- `tgt_idx` in LUT_AW: LUT index for the branch or jump target.
- `alu_zero` in 1: ALU `zero` output for the current instruction.
- `alu_sc_o` in 1: ALU `sc_o` output.
- `sc_we` in 1: latch `alu_sc_o` into the flag register.
- `sc_clr` in 1: clear the flag register.
- `lut_we` in 1: LUT write strobe; honoured only in IDLE or DONE.
- `lut_addr` in LUT_AW: LUT write address.
- `lut_data` in PC_W: LUT write data.
- `pc` out PC_W: current instruction address.
- `sc_i` out 1: registered shift/carry bit, to the ALU.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- FSM states:
  - IDLE: `pc`=0.
  - RUN: executes instructions.
  - DONE: `pc` frozen.
- IDLE -> RUN on `start`. The next cycle has `pc`=0 and `running`=1.
- RUN -> DONE on `halt_req`. `pc` holds its value and `done`=1 from the next cycle.
- DONE -> RUN on `start`. `pc` reloads to 0 and `done` drops.
- `start` is ignored while in RUN.
- Next-pc priority in RUN, highest first:
  1. `halt_req`: hold.
  2. `jmp_en`: `lut[tgt_idx]`.
  3. `br_en && !alu_zero`: `lut[tgt_idx]`.
  4. Otherwise `pc`+1.
- `br_en` with `alu_zero`=1 is not taken and gives `pc`+1.
- `pc`+1 wraps modulo 2^PC_W (max -> 0) with no error.
- Flag register `sc_q`, driven to `sc_i`:
  - Updates only in RUN.
  - `sc_clr` beats `sc_we`.
  - `sc_we` loads `alu_sc_o`.
  - Otherwise `sc_q` holds.
  - Entering RUN from IDLE or DONE clears `sc_q`.
- LUT behaviour:
  - Read is combinational from the registered array.
  - A write takes effect on the edge and is visible the following cycle.
  - `lut_we` in RUN is dropped; contents are unchanged.
- Reset values: state IDLE, `pc`=0, `sc_i`=0, `running`=0, `done`=0, all LUT entries 0.
- Reset in the middle of RUN aborts to IDLE on the next edge, regardless of any other input in that cycle.

## Timing
- Every output is a register or a direct decode of the state register. There is no combinational path from an input to an output.
- Branch latency is 1 cycle: a redirect decided in the cycle with `pc`=N shows the target address in the next cycle. There are no delay slots.
- `alu_zero` and `alu_sc_o` are combinational from the ALU in the same cycle and are sampled at the edge that ends that cycle.
- `start` and `halt_req` asserted in the same cycle while in RUN: halt wins and `start` is ignored.
- `start` asserted in the same cycle as `lut_we` while in IDLE: both take effect. The LUT write is visible from the first RUN cycle.

## Structure
- Package `core_pkg` holds:
  - the FSM enum `fetch_state_t` {IDLE, RUN, DONE};
  - the `PC_W` and `LUT_AW` defaults.
- Sub-module `branch_lut`: a 2^LUT_AW x PC_W register array with synchronous write, combinational read, and synchronous clear on reset.
- FSM, pc arithmetic and `sc_q` live in `fetch_ctl`.

## Test plan
- Reset, then `start` pulse, then 5 idle cycles: `pc` goes 0,1,2,3,4,5 with `running`=1 and `done`=0.
- Load LUT[3]=0x040 in IDLE, start, assert `br_en`=1 with `alu_zero`=0 and `tgt_idx`=3 at `pc`=2: next `pc`=0x040. Repeat with `alu_zero`=1: next `pc`=3.
- `sc_we`=1 with `alu_sc_o`=1 at `pc`=1: `sc_i`=1 from the next cycle. `sc_we`=1 and `sc_clr`=1 together: `sc_i`=0.
- Drive `pc` to 0x3FF with no branch: next `pc`=0x000.
- `halt_req` at `pc`=7: `pc` stays 7, `done`=1, `running`=0. Then `lut_we` to entry 0 is accepted. Then `start`: `pc`=0 and `sc_i`=0.
- `reset` asserted at `pc`=9 in RUN together with `jmp_en`: next cycle `pc`=0, state IDLE, `sc_i`=0, and LUT reads 0 at every index.

Source files
------------

// File: rtl/fetch_ctl_pkg.sv
// Shared definitions for the fetch/flag stage in front of the 8-bit ALU.
// Contents:
//   fetch_state_t : IDLE / RUN / DONE sequencing states
//   PC_W_DEF      : default program counter width
//   LUT_AW_DEF    : default branch-target LUT address width
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_W_DEF   = 10;
  localparam int unsigned LUT_AW_DEF = 4;

endpackage

// File: rtl/fetch_ctl_if.sv
// Decode/ALU-facing bundle of the fetch stage.
// master : decoder/ALU side (drives controls, observes pc/flag/status)
// slave  : fetch_ctl side
//   start, halt_req, br_en, jmp_en, tgt_idx : sequencing and redirect controls
//   alu_zero, alu_sc_o                      : ALU results for the current instruction
//   sc_we, sc_clr                           : flag register controls
//   lut_we, lut_addr, lut_data              : branch-target LUT write port
//   pc, sc_i, running, done                 : registered outputs
interface fetch_ctl_if
  import core_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned LUT_AW = LUT_AW_DEF
);
  logic              start;
  logic              halt_req;
  logic              br_en;
  logic              jmp_en;
  logic [LUT_AW-1:0] tgt_idx;
  logic              alu_zero;
  logic              alu_sc_o;
  logic              sc_we;
  logic              sc_clr;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [PC_W-1:0]   lut_data;
  logic [PC_W-1:0]   pc;
  logic              sc_i;
  logic              running;
  logic              done;

  modport master (
    output start, halt_req, br_en, jmp_en, tgt_idx, alu_zero, alu_sc_o,
           sc_we, sc_clr, lut_we, lut_addr, lut_data,
    input  pc, sc_i, running, done
  );

  modport slave (
    input  start, halt_req, br_en, jmp_en, tgt_idx, alu_zero, alu_sc_o,
           sc_we, sc_clr, lut_we, lut_addr, lut_data,
    output pc, sc_i, running, done
  );
endinterface

// File: rtl/fetch_ctl_branch_lut.sv
// Branch-target lookup table: 2^LUT_AW entries of PC_W bits.
// Synchronous write, combinational read, synchronous clear on reset.
//   clk, reset         : clock, synchronous active-high clear
//   i_we/i_waddr/i_wdata : write port (gated by the caller)
//   i_raddr / o_rdata  : combinational read port
module branch_lut
  import core_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [LUT_AW-1:0] i_waddr,
  input  logic [PC_W-1:0]   i_wdata,
  input  logic [LUT_AW-1:0] i_raddr,
  output logic [PC_W-1:0]   o_rdata
);
  localparam int unsigned DEPTH = 1 << LUT_AW;

  logic [PC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_ctl.sv
// Program counter, shift/carry flag and start/halt sequencing for the
// single-cycle core. All outputs are registers or state decodes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_ctl_if.slave (controls in; pc, sc_i, running, done out)
module fetch_ctl
  import core_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned LUT_AW = LUT_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  fetch_ctl_if.slave  bus
);
  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_sc_q;

  logic [PC_W-1:0] w_tgt;
  logic            w_lut_we;
  logic            w_redirect;

  // LUT is only writable while the program is not executing.
  assign w_lut_we   = bus.lut_we && (r_state != RUN);
  // jmp and taken bne both read lut[tgt_idx], so one select covers both.
  assign w_redirect = bus.jmp_en || (bus.br_en && !bus.alu_zero);

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_lut_we),
    .i_waddr (bus.lut_addr),
    .i_wdata (bus.lut_data),
    .i_raddr (bus.tgt_idx),
    .o_rdata (w_tgt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_sc_q  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_sc_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.sc_clr)     r_sc_q <= 1'b0;
          else if (bus.sc_we) r_sc_q <= bus.alu_sc_o;

          if (bus.halt_req)   r_state <= DONE;
          else if (w_redirect) r_pc   <= w_tgt;
          else                 r_pc   <= r_pc + PC_W'(1);
        end
        default: begin
          r_state <= IDLE;
          r_pc    <= '0;
          r_sc_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc      = r_pc;
  assign bus.sc_i    = r_sc_q;
  assign bus.running = (r_state == RUN);
  assign bus.done    = (r_state == DONE);
endmodule

// File: tb/tb_fetch_ctl.sv
module tb_fetch_ctl;
  localparam int unsigned PC_W   = 10;
  localparam int unsigned LUT_AW = 4;
  localparam int unsigned PC_MOD = 1 << PC_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_ctl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

  fetch_ctl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: 0 = idle, 1 = run, 2 = done
  int          m_state;
  int unsigned m_pc;
  bit          m_sc;
  int unsigned m_lut [16];

  int checks   = 0;
  int failures = 0;

  task automatic clear_inputs();
    bus.start = 0; bus.halt_req = 0; bus.br_en = 0; bus.jmp_en = 0;
    bus.tgt_idx = '0; bus.alu_zero = 0; bus.alu_sc_o = 0;
    bus.sc_we = 0; bus.sc_clr = 0; bus.lut_we = 0;
    bus.lut_addr = '0; bus.lut_data = '0;
  endtask

  // Advance one clock and apply the behavioural rules to the model.
  task automatic step();
    int unsigned tgt;
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_pc = 0; m_sc = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      tgt = m_lut[bus.tgt_idx];
      if (m_state != 1 && bus.lut_we) m_lut[bus.lut_addr] = bus.lut_data;
      if (m_state == 1) begin
        if (bus.sc_clr) m_sc = 0;
        else if (bus.sc_we) m_sc = bus.alu_sc_o;
        if (bus.halt_req) m_state = 2;
        else if (bus.jmp_en || (bus.br_en && !bus.alu_zero)) m_pc = tgt;
        else m_pc = (m_pc + 1) % PC_MOD;
      end else if (bus.start) begin
        m_state = 1; m_pc = 0; m_sc = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1; step(); reset = 0;
  endtask

  task automatic goto_pc(input int unsigned n);
    int unsigned k = 0;
    while (m_pc != n && k < 2000) begin step(); k++; end
    checks++;
    if (bus.pc !== PC_W'(n)) begin
      failures++; $display("FAIL goto_pc got=%0h want=%0h", bus.pc, n);
    end
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs(); step(); step(); reset = 0;
    checks++; if (bus.pc !== '0) begin failures++; $display("FAIL reset_pc got=%0h want=0", bus.pc); end
    checks++; if (bus.sc_i !== 1'b0) begin failures++; $display("FAIL reset_sc got=%b want=0", bus.sc_i); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b want=0", bus.running); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
  endtask

  task automatic test_sequential();
    bus.start = 1; step(); bus.start = 0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      checks++;
      if (bus.pc !== PC_W'(k) || bus.running !== 1'b1 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL seq pc got=%0h/%b/%b want=%0h/1/0", bus.pc, bus.running, bus.done, k);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    bus.lut_we = 1; bus.lut_addr = 3; bus.lut_data = 10'h040; step(); bus.lut_we = 0;
    bus.start = 1; step(); bus.start = 0;
    goto_pc(2);
    bus.br_en = 1; bus.tgt_idx = 3; bus.alu_zero = 0; step(); bus.br_en = 0;
    checks++; if (bus.pc !== 10'h040) begin failures++; $display("FAIL bne_taken got=%0h want=40", bus.pc); end
    bus.halt_req = 1; step(); bus.halt_req = 0;
    bus.start = 1; step(); bus.start = 0;
    goto_pc(2);
    bus.br_en = 1; bus.tgt_idx = 3; bus.alu_zero = 1; step(); bus.br_en = 0; bus.alu_zero = 0;
    checks++; if (bus.pc !== 10'h003) begin failures++; $display("FAIL bne_not_taken got=%0h want=3", bus.pc); end
  endtask

  task automatic test_flag();
    do_reset();
    bus.start = 1; step(); bus.start = 0;
    goto_pc(1);
    bus.sc_we = 1; bus.alu_sc_o = 1; step(); bus.sc_we = 0; bus.alu_sc_o = 0;
    checks++; if (bus.sc_i !== 1'b1) begin failures++; $display("FAIL sc_load got=%b want=1", bus.sc_i); end
    step();
    checks++; if (bus.sc_i !== 1'b1) begin failures++; $display("FAIL sc_hold got=%b want=1", bus.sc_i); end
    bus.sc_we = 1; bus.sc_clr = 1; bus.alu_sc_o = 1; step();
    bus.sc_we = 0; bus.sc_clr = 0; bus.alu_sc_o = 0;
    checks++; if (bus.sc_i !== 1'b0) begin failures++; $display("FAIL sc_clr_wins got=%b want=0", bus.sc_i); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.lut_we = 1; bus.lut_addr = 5; bus.lut_data = 10'h3FE; step(); bus.lut_we = 0;
    bus.start = 1; step(); bus.start = 0;
    bus.jmp_en = 1; bus.tgt_idx = 5; step(); bus.jmp_en = 0;
    checks++; if (bus.pc !== 10'h3FE) begin failures++; $display("FAIL jmp got=%0h want=3fe", bus.pc); end
    step();
    checks++; if (bus.pc !== 10'h3FF) begin failures++; $display("FAIL pc_max got=%0h want=3ff", bus.pc); end
    step();
    checks++; if (bus.pc !== 10'h000) begin failures++; $display("FAIL pc_wrap got=%0h want=0", bus.pc); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.start = 1; step(); bus.start = 0;
    goto_pc(5);
    bus.sc_we = 1; bus.alu_sc_o = 1; step(); bus.sc_we = 0; bus.alu_sc_o = 0;
    goto_pc(7);
    bus.halt_req = 1; step(); bus.halt_req = 0;
    checks++;
    if (bus.pc !== 10'd7 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
      failures++; $display("FAIL halt got=%0h/%b/%b want=7/1/0", bus.pc, bus.done, bus.running);
    end
    step();
    checks++; if (bus.pc !== 10'd7) begin failures++; $display("FAIL done_freeze got=%0h want=7", bus.pc); end
    bus.lut_we = 1; bus.lut_addr = 0; bus.lut_data = 10'h123; step(); bus.lut_we = 0;
    bus.start = 1; step(); bus.start = 0;
    checks++;
    if (bus.pc !== '0 || bus.sc_i !== 1'b0 || bus.done !== 1'b0 || bus.running !== 1'b1) begin
      failures++; $display("FAIL restart got=%0h/%b/%b/%b want=0/0/0/1", bus.pc, bus.sc_i, bus.done, bus.running);
    end
    bus.jmp_en = 1; bus.tgt_idx = 0; step(); bus.jmp_en = 0;
    checks++; if (bus.pc !== 10'h123) begin failures++; $display("FAIL done_lut_write got=%0h want=123", bus.pc); end
    bus.start = 1; bus.halt_req = 1; step(); bus.start = 0; bus.halt_req = 0;
    checks++;
    if (bus.pc !== 10'h123 || bus.done !== 1'b1) begin
      failures++; $display("FAIL halt_beats_start got=%0h/%b want=123/1", bus.pc, bus.done);
    end
  endtask

  task automatic test_run_rules();
    do_reset();
    bus.start = 1; step(); step(); step(); // pc 0 -> 1 -> 2, start held
    checks++; if (bus.pc !== 10'd2) begin failures++; $display("FAIL start_in_run got=%0h want=2", bus.pc); end
    bus.start = 0;
    bus.lut_we = 1; bus.lut_addr = 2; bus.lut_data = 10'h055; step(); bus.lut_we = 0;
    bus.jmp_en = 1; bus.tgt_idx = 2; step(); bus.jmp_en = 0;
    checks++; if (bus.pc !== 10'h000) begin failures++; $display("FAIL lut_we_in_run got=%0h want=0", bus.pc); end
    do_reset();
    bus.start = 1; bus.lut_we = 1; bus.lut_addr = 1; bus.lut_data = 10'h077; step();
    bus.start = 0; bus.lut_we = 0;
    bus.jmp_en = 1; bus.tgt_idx = 1; step(); bus.jmp_en = 0;
    checks++; if (bus.pc !== 10'h077) begin failures++; $display("FAIL start_with_lut_we got=%0h want=77", bus.pc); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.lut_we = 1; bus.lut_addr = LUT_AW'(i); bus.lut_data = PC_W'(32'h100 + i); step();
    end
    bus.lut_we = 0;
    bus.start = 1; step(); bus.start = 0;
    bus.sc_we = 1; bus.alu_sc_o = 1; step(); bus.sc_we = 0; bus.alu_sc_o = 0;
    goto_pc(9);
    reset = 1; bus.jmp_en = 1; bus.tgt_idx = 4; bus.start = 1; step();
    reset = 0; bus.jmp_en = 0; bus.start = 0;
    checks++;
    if (bus.pc !== '0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.sc_i !== 1'b0) begin
      failures++; $display("FAIL mid_run_reset got=%0h/%b/%b/%b want=0/0/0/0", bus.pc, bus.running, bus.done, bus.sc_i);
    end
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 16; i++) begin
      bus.jmp_en = 1; bus.tgt_idx = LUT_AW'(i); step();
      checks++;
      if (bus.pc !== '0) begin failures++; $display("FAIL lut_cleared idx=%0d got=%0h want=0", i, bus.pc); end
    end
    bus.jmp_en = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.start    = ($urandom_range(0, 19) == 0);
      bus.halt_req = ($urandom_range(0, 29) == 0);
      bus.jmp_en   = ($urandom_range(0, 9) == 0);
      bus.br_en    = ($urandom_range(0, 4) == 0);
      bus.tgt_idx  = LUT_AW'($urandom);
      bus.alu_zero = 1'($urandom);
      bus.alu_sc_o = 1'($urandom);
      bus.sc_we    = 1'($urandom);
      bus.sc_clr   = ($urandom_range(0, 3) == 0);
      bus.lut_we   = ($urandom_range(0, 3) == 0);
      bus.lut_addr = LUT_AW'($urandom);
      bus.lut_data = PC_W'($urandom);
      reset        = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if (bus.pc !== PC_W'(m_pc) || bus.sc_i !== m_sc ||
          bus.running !== (m_state == 1) || bus.done !== (m_state == 2)) begin
        failures++;
        $display("FAIL random cyc=%0d got pc=%0h sc=%b run=%b done=%b want pc=%0h sc=%b state=%0d",
                 n, bus.pc, bus.sc_i, bus.running, bus.done, m_pc, m_sc, m_state);
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    m_state = 0; m_pc = 0; m_sc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_flag();
    test_wrap();
    test_halt();
    test_run_rules();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
